// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if
//   Bus bundle between the decode/writeback stages (master) and the register
//   file (slave).
//   master drives: readAddress1/2, writeEnable, writeAddress, writeData,
//                  reserveEnable, reserveAddress
//   slave drives:  data1/2, busy1/2, reserveConflict, pendingCount
interface regfile_scoreboard_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] readAddress1;
  logic [ADDR_WIDTH-1:0] readAddress2;
  logic [DATA_WIDTH-1:0] data1;
  logic [DATA_WIDTH-1:0] data2;
  logic                  busy1;
  logic                  busy2;
  logic                  writeEnable;
  logic [ADDR_WIDTH-1:0] writeAddress;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  reserveEnable;
  logic [ADDR_WIDTH-1:0] reserveAddress;
  logic                  reserveConflict;
  logic [ADDR_WIDTH:0]   pendingCount;

  modport master (
    output readAddress1, readAddress2,
    output writeEnable, writeAddress, writeData,
    output reserveEnable, reserveAddress,
    input  data1, data2, busy1, busy2,
    input  reserveConflict, pendingCount
  );

  modport slave (
    input  readAddress1, readAddress2,
    input  writeEnable, writeAddress, writeData,
    input  reserveEnable, reserveAddress,
    output data1, data2, busy1, busy2,
    output reserveConflict, pendingCount
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Parametrised register file with per-register pending-write scoreboard.
//   Decode reads operands and reserves destinations; writeback retires
//   results and clears the pending bit.
// Ports:
//   clk   rising-edge clock
//   rstn  synchronous active-low reset: clears data, pending bits, counters
//   bus   regfile_scoreboard_if.slave
//         readAddress1/2 -> data1/2, busy1/2 (combinational)
//         writeEnable/writeAddress/writeData (writeback, no handshake)
//         reserveEnable/reserveAddress (issue, sets pending)
//         reserveConflict (registered pulse), pendingCount (registered)
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b1
) (
  input logic                 clk,
  input logic                 rstn,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_pending [DEPTH];
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_conflict;

  logic w_wr_ok;
  logic w_rsv_ok;
  logic w_same_idx;
  logic w_cnt_inc;
  logic w_cnt_dec;

  // Register 0 swallows writes and reservations when hardwired to zero.
  always_comb begin
    w_wr_ok    = bus.writeEnable && !(ZERO_REG && (bus.writeAddress == '0));
    w_rsv_ok   = bus.reserveEnable && !(ZERO_REG && (bus.reserveAddress == '0));
    w_same_idx = (bus.writeAddress == bus.reserveAddress);
    // A reserve sets at most one bit and a write clears at most one bit, so
    // the count moves by -1/0/+1. When both hit the same index the reserve
    // wins: that bit cannot count as cleared.
    w_cnt_inc  = w_rsv_ok && !r_pending[bus.reserveAddress];
    w_cnt_dec  = w_wr_ok && r_pending[bus.writeAddress] && !(w_rsv_ok && w_same_idx);
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    logic w_hit_wr;
    logic w_hit_rsv;

    assign w_hit_wr  = w_wr_ok && (bus.writeAddress == ADDR_WIDTH'(gi));
    assign w_hit_rsv = w_rsv_ok && (bus.reserveAddress == ADDR_WIDTH'(gi));

    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_mem[gi]     <= '0;
        r_pending[gi] <= 1'b0;
      end else begin
        if (w_hit_wr) begin
          r_mem[gi] <= bus.writeData;
        end
        // New producer wins over the retiring one.
        if (w_hit_rsv) begin
          r_pending[gi] <= 1'b1;
        end else if (w_hit_wr) begin
          r_pending[gi] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count    <= '0;
      r_conflict <= 1'b0;
    end else begin
      // A writeback to the same index retires the old producer this cycle,
      // so the reservation is not a conflict.
      r_conflict <= w_rsv_ok && r_pending[bus.reserveAddress] &&
                    !(bus.writeEnable && w_same_idx);
      case ({w_cnt_inc, w_cnt_dec})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    bus.data1 = r_mem[bus.readAddress1];
    bus.busy1 = r_pending[bus.readAddress1];
    if (BYPASS && w_wr_ok && (bus.writeAddress == bus.readAddress1)) begin
      bus.data1 = bus.writeData;
      bus.busy1 = 1'b0;
    end
    if (ZERO_REG && (bus.readAddress1 == '0)) begin
      bus.data1 = '0;
      bus.busy1 = 1'b0;
    end
  end

  always_comb begin
    bus.data2 = r_mem[bus.readAddress2];
    bus.busy2 = r_pending[bus.readAddress2];
    if (BYPASS && w_wr_ok && (bus.writeAddress == bus.readAddress2)) begin
      bus.data2 = bus.writeData;
      bus.busy2 = 1'b0;
    end
    if (ZERO_REG && (bus.readAddress2 == '0)) begin
      bus.data2 = '0;
      bus.busy2 = 1'b0;
    end
  end

  assign bus.reserveConflict = r_conflict;
  assign bus.pendingCount    = r_count;
endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        we;
  logic        re;
  logic [4:0]  wa;
  logic [4:0]  ra;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] wd;

  int total = 0;
  int bad   = 0;

  regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifb ();
  regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifn ();

  assign ifb.readAddress1   = ra1;
  assign ifb.readAddress2   = ra2;
  assign ifb.writeEnable    = we;
  assign ifb.writeAddress   = wa;
  assign ifb.writeData      = wd;
  assign ifb.reserveEnable  = re;
  assign ifb.reserveAddress = ra;
  assign ifn.readAddress1   = ra1;
  assign ifn.readAddress2   = ra2;
  assign ifn.writeEnable    = we;
  assign ifn.writeAddress   = wa;
  assign ifn.writeData      = wd;
  assign ifn.reserveEnable  = re;
  assign ifn.reserveAddress = ra;

  regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1), .ZERO_REG(1'b1))
    dut_b (.clk(clk), .rstn(rstn), .bus(ifb));
  regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0), .ZERO_REG(1'b1))
    dut_n (.clk(clk), .rstn(rstn), .bus(ifn));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Directed vectors: inputs held for one cycle, outputs compared just
  // before the closing edge (registered outputs reflect earlier edges).
  typedef struct {
    bit          rs, w, r;
    logic [4:0]  wa, ra, a1, a2;
    logic [31:0] wd;
    logic [31:0] d1, d2;   // BYPASS=1 build
    bit          b1, b2;   // BYPASS=1 build
    logic [31:0] nd2;      // BYPASS=0 build, port 2 data
    bit          nb1;      // BYPASS=0 build, port 1 busy
    bit          conf;
    logic [5:0]  cnt;
  } tv_t;

  tv_t vecs[$];

  function automatic tv_t mk(input bit rs_i, input bit w_i, input int wa_i, input logic [31:0] wd_i,
                             input bit r_i, input int ra_i, input int a1_i, input int a2_i,
                             input logic [31:0] d1_i, input logic [31:0] d2_i, input bit b1_i,
                             input bit b2_i, input logic [31:0] nd2_i, input bit nb1_i,
                             input bit c_i, input int cnt_i);
    tv_t t;
    t.rs = rs_i; t.w = w_i; t.r = r_i;
    t.wa = 5'(wa_i); t.ra = 5'(ra_i); t.a1 = 5'(a1_i); t.a2 = 5'(a2_i);
    t.wd = wd_i; t.d1 = d1_i; t.d2 = d2_i; t.b1 = b1_i; t.b2 = b2_i;
    t.nd2 = nd2_i; t.nb1 = nb1_i; t.conf = c_i; t.cnt = 6'(cnt_i);
    return t;
  endfunction

  // Behavioural reference for the random phase.
  logic [31:0] m_mem [32];
  bit          m_pend [32];
  bit          m_conf;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic logic [32:0] model_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 33'd0;
    if (byp && we && (wa == a)) return {1'b0, wd};
    return {m_pend[a], m_mem[a]};
  endfunction

  task automatic model_edge();
    if (!rstn) begin
      model_reset();
    end else begin
      m_conf = re && (ra != 5'd0) && m_pend[ra] && !(we && (wa == ra));
      if (we && (wa != 5'd0)) begin
        m_mem[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (re && (ra != 5'd0)) m_pend[ra] = 1'b1;
    end
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [32:0] e;

    //            rs   w    wa  wd            r    ra  a1  a2  d1  d2  b1   b2   nd2 nb1  conf cnt
    vecs.push_back(mk(1'b1,1'b1, 7, 5,          1'b0, 0,  7,  7,  5,  5, 1'b0,1'b0, 0, 1'b0,1'b0,0));
    vecs.push_back(mk(1'b0,1'b1, 9, 'h77,       1'b1, 3,  7,  7,  5,  5, 1'b0,1'b0, 5, 1'b0,1'b0,0));
    vecs.push_back(mk(1'b1,1'b0, 0, 0,          1'b0, 0,  7,  9,  0,  0, 1'b0,1'b0, 0, 1'b0,1'b0,0));
    vecs.push_back(mk(1'b1,1'b0, 0, 0,          1'b0, 0,  3,  3,  0,  0, 1'b0,1'b0, 0, 1'b0,1'b0,0));
    vecs.push_back(mk(1'b1,1'b1, 0, 'hDEADBEEF, 1'b1, 0,  0,  0,  0,  0, 1'b0,1'b0, 0, 1'b0,1'b0,0));
    vecs.push_back(mk(1'b1,1'b0, 0, 0,          1'b0, 0,  0,  0,  0,  0, 1'b0,1'b0, 0, 1'b0,1'b0,0));
    vecs.push_back(mk(1'b1,1'b1, 18, 4,         1'b0, 0,  1,  1,  0,  0, 1'b0,1'b0, 0, 1'b0,1'b0,0));
    vecs.push_back(mk(1'b1,1'b1, 18, 13,        1'b0, 0, 18, 18, 13, 13, 1'b0,1'b0, 4, 1'b0,1'b0,0));
    vecs.push_back(mk(1'b1,1'b0, 0, 0,          1'b0, 0, 18, 18, 13, 13, 1'b0,1'b0,13, 1'b0,1'b0,0));
    vecs.push_back(mk(1'b1,1'b0, 0, 0,          1'b1,19, 19, 19,  0,  0, 1'b0,1'b0, 0, 1'b0,1'b0,0));
    vecs.push_back(mk(1'b1,1'b0, 0, 0,          1'b0, 0, 19, 19,  0,  0, 1'b1,1'b1, 0, 1'b1,1'b0,1));
    vecs.push_back(mk(1'b1,1'b1, 19, 10,        1'b0, 0, 19, 19, 10, 10, 1'b0,1'b0, 0, 1'b1,1'b0,1));
    vecs.push_back(mk(1'b1,1'b0, 0, 0,          1'b0, 0, 19, 19, 10, 10, 1'b0,1'b0,10, 1'b0,1'b0,0));
    vecs.push_back(mk(1'b1,1'b0, 0, 0,          1'b1, 5,  5,  5,  0,  0, 1'b0,1'b0, 0, 1'b0,1'b0,0));
    vecs.push_back(mk(1'b1,1'b1, 5, 7,          1'b1, 5,  5,  5,  7,  7, 1'b0,1'b0, 0, 1'b1,1'b0,1));
    vecs.push_back(mk(1'b1,1'b0, 0, 0,          1'b0, 0,  5,  5,  7,  7, 1'b1,1'b1, 7, 1'b1,1'b0,1));
    vecs.push_back(mk(1'b1,1'b0, 0, 0,          1'b1, 5,  5,  5,  7,  7, 1'b1,1'b1, 7, 1'b1,1'b0,1));
    vecs.push_back(mk(1'b1,1'b0, 0, 0,          1'b0, 0,  5,  5,  7,  7, 1'b1,1'b1, 7, 1'b1,1'b1,1));
    vecs.push_back(mk(1'b1,1'b0, 0, 0,          1'b0, 0,  5,  5,  7,  7, 1'b1,1'b1, 7, 1'b1,1'b0,1));
    vecs.push_back(mk(1'b1,1'b1, 5, 8,          1'b0, 0,  5,  5,  8,  8, 1'b0,1'b0, 7, 1'b1,1'b0,1));
    vecs.push_back(mk(1'b1,1'b0, 0, 0,          1'b0, 0,  5,  5,  8,  8, 1'b0,1'b0, 8, 1'b0,1'b0,0));

    // Initial reset.
    rstn = 1'b0; we = 1'b0; re = 1'b0; wa = '0; ra = '0; ra1 = '0; ra2 = '0; wd = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      rstn = vecs[i].rs; we = vecs[i].w; wa = vecs[i].wa; wd = vecs[i].wd;
      re = vecs[i].r; ra = vecs[i].ra; ra1 = vecs[i].a1; ra2 = vecs[i].a2;
      @(negedge clk);
      chk($sformatf("vec%0d data1", i), ifb.data1, vecs[i].d1);
      chk($sformatf("vec%0d data2", i), ifb.data2, vecs[i].d2);
      chk($sformatf("vec%0d busy1", i), 32'(ifb.busy1), 32'(vecs[i].b1));
      chk($sformatf("vec%0d busy2", i), 32'(ifb.busy2), 32'(vecs[i].b2));
      chk($sformatf("vec%0d nobyp data2", i), ifn.data2, vecs[i].nd2);
      chk($sformatf("vec%0d nobyp busy1", i), 32'(ifn.busy1), 32'(vecs[i].nb1));
      chk($sformatf("vec%0d conflict", i), 32'(ifb.reserveConflict), 32'(vecs[i].conf));
      chk($sformatf("vec%0d count", i), 32'(ifb.pendingCount), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d nobyp count", i), 32'(ifn.pendingCount), 32'(vecs[i].cnt));
      $display("vec %0d: rstn=%0d we=%0d wa=%0d wd=0x%0h re=%0d ra=%0d rd=%0d/%0d -> d1=0x%0h d2=0x%0h cnt=%0d",
               i, rstn, we, wa, wd, re, ra, ra1, ra2, ifb.data1, ifb.data2, ifb.pendingCount);
      @(posedge clk);
      #1;
    end

    // Fill: reserve 1..31, then re-reserve 31 (count saturates naturally).
    rstn = 1'b1; we = 1'b0; wa = '0; wd = '0;
    for (int i = 1; i < 32; i++) begin
      re = 1'b1; ra = 5'(i); ra1 = 5'(i); ra2 = 5'(i);
      @(posedge clk);
      #1;
      chk($sformatf("fill%0d count", i), 32'(ifb.pendingCount), 32'(i));
      chk($sformatf("fill%0d conflict", i), 32'(ifb.reserveConflict), 32'd0);
      $display("fill reserve r%0d -> count=%0d", i, ifb.pendingCount);
    end
    re = 1'b1; ra = 5'd31;
    @(posedge clk);
    #1;
    chk("refill count", 32'(ifb.pendingCount), 32'd31);
    chk("refill conflict", 32'(ifb.reserveConflict), 32'd1);
    $display("re-reserve r31 -> count=%0d conflict=%0d", ifb.pendingCount, ifb.reserveConflict);
    re = 1'b0;
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'(i * 3);
      @(posedge clk);
      #1;
      chk($sformatf("drain%0d count", i), 32'(ifb.pendingCount), 32'(31 - i));
      $display("drain write r%0d=0x%0h -> count=%0d", i, wd, ifb.pendingCount);
    end
    we = 1'b0; ra1 = 5'd31; ra2 = 5'd17;
    @(negedge clk);
    chk("drain r31 data", ifn.data1, 32'd93);
    chk("drain r17 data", ifn.data2, 32'd51);
    chk("drain r31 busy", 32'(ifn.busy1), 32'd0);

    // Random phase against the reference model.
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      rstn = ($urandom_range(0, 63) != 0);
      we   = 1'($urandom_range(0, 1));
      re   = 1'($urandom_range(0, 1));
      wa   = rnd_addr();
      ra   = rnd_addr();
      ra1  = rnd_addr();
      ra2  = ($urandom_range(0, 3) == 0) ? wa : rnd_addr();
      wd   = $urandom;
      @(negedge clk);
      e = model_read(ra1, 1'b1);
      chk("rnd b data1", ifb.data1, e[31:0]);
      chk("rnd b busy1", 32'(ifb.busy1), 32'(e[32]));
      e = model_read(ra2, 1'b1);
      chk("rnd b data2", ifb.data2, e[31:0]);
      chk("rnd b busy2", 32'(ifb.busy2), 32'(e[32]));
      e = model_read(ra1, 1'b0);
      chk("rnd n data1", ifn.data1, e[31:0]);
      chk("rnd n busy1", 32'(ifn.busy1), 32'(e[32]));
      e = model_read(ra2, 1'b0);
      chk("rnd n data2", ifn.data2, e[31:0]);
      chk("rnd n busy2", 32'(ifn.busy2), 32'(e[32]));
      chk("rnd conflict", 32'(ifb.reserveConflict), 32'(m_conf));
      chk("rnd count", 32'(ifb.pendingCount), 32'(model_count()));
      chk("rnd n count", 32'(ifn.pendingCount), 32'(model_count()));
      $display("rnd %0d: rstn=%0d we=%0d wa=%0d re=%0d ra=%0d rd=%0d/%0d cnt=%0d",
               c, rstn, we, wa, re, ra, ra1, ra2, ifb.pendingCount);
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file for the Mini-MIPS datapath, the successor to the fixed 32×32 register file. It adds configurable data width and depth, synchronous clearing on reset, a hardwired zero register, optional write-to-read bypass, and a per-register pending-write scoreboard. The decode stage reads operands and reserves destinations through it; the writeback stage retires results into it. The decode stage uses the busy outputs to decide stalls.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH
- BYPASS, 1, when 1 a same-cycle writeback is forwarded to the read ports and the busy flags
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes and reservations

Ports:
- clk  input  1  rising-edge clock, sole clock
- rstn  input  1  reset, synchronous, active-low
- readAddress1  input  ADDR_WIDTH  read port 1 index
- readAddress2  input  ADDR_WIDTH  read port 2 index
- data1  output  DATA_WIDTH  read port 1 data (combinational)
- data2  output  DATA_WIDTH  read port 2 data (combinational)
- busy1  output  1  register at readAddress1 has an outstanding writer (combinational)
- busy2  output  1  register at readAddress2 has an outstanding writer (combinational)
- writeEnable  input  1  writeback strobe
- writeAddress  input  ADDR_WIDTH  writeback index
- writeData  input  DATA_WIDTH  writeback value
- reserveEnable  input  1  issue strobe; marks reserveAddress pending
- reserveAddress  input  ADDR_WIDTH  destination being issued
- reserveConflict  output  1  registered; reservation hit an already-pending register
- pendingCount  output  ADDR_WIDTH+1  registered count of pending registers

## Operation
- Storage: 2**ADDR_WIDTH × DATA_WIDTH array plus one pending bit per register.
- Reset (rstn=0 at a rising edge): every register is cleared to 0, all pending bits to 0, pendingCount to 0 and reserveConflict to 0. Reset overrides any write or reserve in the same cycle.
- Register 0 with ZERO_REG=1:
  - Writes to register 0 are dropped.
  - Reservations of register 0 are dropped and never raise a conflict.
  - data1/data2 read 0 for index 0.
  - busy1/busy2 read 0 for index 0.
- Write: at a rising edge with writeEnable=1, array[writeAddress] <= writeData and pending[writeAddress] is cleared. Writing a register that is not pending is legal and stores the data.
- Reserve: at a rising edge with reserveEnable=1, pending[reserveAddress] is set.
- Reserve and write to the same index in the same cycle: the data is stored and the pending bit ends at 1. The new producer wins.
- reserveConflict:
  - Next cycle it equals reserveEnable & pending[reserveAddress] (the pre-edge value) & ~(writeEnable & writeAddress==reserveAddress).
  - It is a one-cycle pulse per offending reservation; the reservation still takes effect.
- pendingCount:
  - Next cycle it equals current + (bit newly set) − (bit newly cleared), evaluated on pre- and post-edge pending bits.
  - Range is 0..2**ADDR_WIDTH (or 2**ADDR_WIDTH−1 with ZERO_REG=1). It never wraps.
- Read, BYPASS=1:
  - If writeEnable=1 and writeAddress equals readAddressN, dataN = writeData and busyN = 0. This excludes index 0 when ZERO_REG=1.
  - Otherwise dataN = array[readAddressN] and busyN = pending[readAddressN].
- Read, BYPASS=0: data and busy always come from the stored state; the written value is visible the cycle after the edge.
- The two read ports are independent. Both may address the same register.

## Timing
- Write latency: 1 edge to array; 0 cycles to the read ports with BYPASS=1.
- Reserve to busy latency: 1 edge. busyN is high from the cycle after reservation until the cycle of the matching writeback (BYPASS=1) or the cycle after it (BYPASS=0).
- reserveConflict and pendingCount update on the same edge as the causing reserve or write.
- Reset mid-operation: outstanding reservations are discarded, and a writeback in the reset cycle is lost.
- There is no handshake on the write port: every asserted writeEnable cycle is accepted.

## Test plan
- Reset: preload r7=5 via write, pulse rstn=0 one cycle -> data1 at index 7 = 0, pendingCount=0, busy1=0.
- Zero reg: write 0xDEADBEEF to r0 and reserve r0 -> data1(r0)=0, busy1=0, pendingCount stays 0, no conflict.
- Bypass: BYPASS=1, write r18=13 while readAddress2=18 in the same cycle -> data2=13 that cycle; BYPASS=0 build -> data2=old value, then 13 the next cycle.
- Scoreboard: reserve r19 -> next cycle busy1(r19)=1 and pendingCount=1; writeback r19=10 -> busy1=0 (BYPASS=1) that cycle, pendingCount=0 after the edge.
- Collision: r5 pending; in the same cycle write r5=7 and reserve r5 -> r5 reads 7, pending stays 1, pendingCount unchanged, reserveConflict=0. Then reserve r5 alone -> reserveConflict=1 for exactly one cycle.
- Fill: reserve every index 1..31 on consecutive cycles -> pendingCount reaches 31 with no wrap; write all back -> pendingCount returns to 0.
